// File: rtl/fpu_f2i_conv_if.sv
// Operand/result handshake bundle for the float-to-integer converter.
// The master side issues operands and consumes results; the slave side is the converter.
interface fpu_f2i_conv_if #(
  parameter int man   = 22,
  parameter int exp   = 7,
  parameter int int_w = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [exp+man+2:0]   in_float;
  logic [2:0]           in_rm;
  logic                 in_unsigned;
  logic                 out_valid;
  logic                 out_ready;
  logic [int_w-1:0]     out_int;
  logic                 out_nv;
  logic                 out_nx;

  modport master (
    output in_valid, in_float, in_rm, in_unsigned, out_ready,
    input  in_ready, out_valid, out_int, out_nv, out_nx
  );

  modport slave (
    input  in_valid, in_float, in_rm, in_unsigned, out_ready,
    output in_ready, out_valid, out_int, out_nv, out_nx
  );
endinterface

// File: rtl/fpu_f2i_conv.sv
// Two-stage float-to-integer converter: stage 1 unpacks and classifies the operand,
// stage 2 denormalises the significand, rounds per RISC-V frm and saturates with NV/NX.
module fpu_f2i_conv #(
  parameter int man   = 22,
  parameter int exp   = 7,
  parameter int int_w = 32
) (
  input  logic           clk,
  input  logic           rst,
  fpu_f2i_conv_if.slave  io
);

  localparam int FW = exp + man + 3;
  localparam int SW = man + 2;
  localparam int EW = exp + 2;
  localparam int MW = int_w + 1;
  localparam int XW = 2 * SW;

  localparam logic [EW-1:0]    BIAS   = EW'((1 << exp) - 1);
  localparam logic [int_w-1:0] SMAX   = {1'b0, {(int_w-1){1'b1}}};
  localparam logic [int_w-1:0] SMIN   = {1'b1, {(int_w-1){1'b0}}};
  localparam logic [MW-1:0]    SMAX_W = MW'(SMAX);
  localparam logic [MW-1:0]    SMIN_W = MW'(SMIN);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic                 sign;
    logic [2:0]           rm;
    logic                 uns;
    logic                 zero;
    logic                 nan;
    logic                 ovf;
    logic [SW-1:0]        sig;
    logic signed [EW-1:0] e;
  } s1_t;

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s1_advance, in_ready, in_fire;

  assign s1_advance = !s2_valid_q | io.out_ready;
  assign in_ready   = !s1_valid_q | s1_advance;
  assign in_fire    = io.in_valid & in_ready;

  // ---------------- stage 1: unpack / classify ----------------
  logic                 in_sign;
  logic [exp:0]         in_bexp;
  logic [man:0]         in_frac;
  logic                 exp_max, exp_min;
  logic signed [EW-1:0] in_e;
  s1_t                  s1_d, s1_q;

  assign in_sign = io.in_float[FW-1];
  assign in_bexp = io.in_float[FW-2:man+1];
  assign in_frac = io.in_float[man:0];
  assign exp_max = &in_bexp;
  assign exp_min = ~|in_bexp;

  // Subnormals share the minimum normal exponent; only the hidden bit differs.
  assign in_e = exp_min ? $signed(EW'(1) - BIAS) : $signed({1'b0, in_bexp} - BIAS);

  always_comb begin
    s1_d.sign = in_sign;
    s1_d.rm   = io.in_float[0] ? io.in_rm : io.in_rm;
    s1_d.uns  = io.in_unsigned;
    s1_d.zero = exp_min & ~|in_frac;
    s1_d.nan  = exp_max & |in_frac;
    s1_d.ovf  = exp_max | (int'(in_e) >= int_w);
    s1_d.sig  = {~exp_min, in_frac};
    s1_d.e    = in_e;
  end

  // NOTE: payload registers carry no reset; they are only observed while their valid bit is set.
  always_ff @(posedge clk) begin
    if (in_fire) s1_q <= s1_d;
  end

  // ---------------- stage 2: shift / round / saturate ----------------
  int               e_i;
  logic [XW-1:0]    ext;
  logic [MW-1:0]    mag, mag_r;
  logic [int_w-1:0] mag_lo, res_d;
  logic             guard, sticky, nx_raw, inc, nv_d, nx_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    e_i    = int'($signed(s1_q.e));
    ext    = '0;
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (e_i > man + 1) begin
      mag = MW'(s1_q.sig) << (e_i - (man + 1));
    end else if (e_i >= -1) begin
      ext    = {s1_q.sig, SW'(0)} >> ((man + 1) - e_i);
      mag    = MW'(ext[XW-1:SW]);
      guard  = ext[SW-1];
      sticky = |ext[SW-2:0];
    end else begin
      sticky = |s1_q.sig;
    end

    nx_raw = guard | sticky;
    case (rm_e'(s1_q.rm))
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_q.sign & nx_raw;
      RM_RUP:  inc = !s1_q.sign & nx_raw;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mag[0]);
    endcase
    mag_r  = mag + MW'(inc);
    mag_lo = mag_r[int_w-1:0];

    res_d = '0;
    nv_d  = 1'b0;
    nx_d  = 1'b0;
    if (s1_q.nan) begin
      res_d = s1_q.uns ? '1 : SMAX;
      nv_d  = 1'b1;
    end else if (s1_q.ovf) begin
      if (s1_q.sign) res_d = s1_q.uns ? '0 : SMIN;
      else           res_d = s1_q.uns ? '1 : SMAX;
      nv_d = 1'b1;
    end else if (s1_q.zero) begin
      res_d = '0;
    end else if (s1_q.uns) begin
      // A negative value is only legal for unsigned if it rounds to zero.
      if (s1_q.sign) begin
        if (|mag_r) nv_d = 1'b1;
        else        nx_d = nx_raw;
      end else if (mag_r[int_w]) begin
        res_d = '1;
        nv_d  = 1'b1;
      end else begin
        res_d = mag_lo;
        nx_d  = nx_raw;
      end
    end else begin
      if (!s1_q.sign && (mag_r > SMAX_W)) begin
        res_d = SMAX;
        nv_d  = 1'b1;
      end else if (s1_q.sign && (mag_r > SMIN_W)) begin
        res_d = SMIN;
        nv_d  = 1'b1;
      end else begin
        res_d = s1_q.sign ? (~mag_lo + int_w'(1)) : mag_lo;
        nx_d  = nx_raw;
      end
    end
  end

  // ---------------- control and output registers ----------------
  logic [int_w-1:0] out_int_q;
  logic             out_nv_q, out_nx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_int_q  <= '0;
      out_nv_q   <= 1'b0;
      out_nx_q   <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= io.in_valid;
      if (s1_advance) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_int_q <= res_d;
          out_nv_q  <= nv_d;
          out_nx_q  <= nx_d;
        end
      end
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = s2_valid_q;
  assign io.out_int   = out_int_q;
  assign io.out_nv    = out_nv_q;
  assign io.out_nx    = out_nx_q;

endmodule
